// File: rtl/gate_check_pkg.sv
// Shared types and constants for the two-input gate vector checker.
// Holds the FSM state enum, the dut_f bit positions and the bus widths.
package gate_check_pkg;

    localparam int VEC_W = 2;
    localparam int RES_W = 6;
    localparam int CNT_W = 4;

    localparam int IDX_AND  = 0;
    localparam int IDX_OR   = 1;
    localparam int IDX_XOR  = 2;
    localparam int IDX_NAND = 3;
    localparam int IDX_NOR  = 4;
    localparam int IDX_XNOR = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/gate_golden.sv
// Combinational reference for the six two-input gates, packed in dut_f bit order.
module gate_golden
    import gate_check_pkg::*;
(
    input  logic             a,
    input  logic             b,
    output logic [RES_W-1:0] f
);

    always_comb begin
        f           = '0;
        f[IDX_AND]  = a & b;
        f[IDX_OR]   = a | b;
        f[IDX_XOR]  = a ^ b;
        f[IDX_NAND] = ~(a & b);
        f[IDX_NOR]  = ~(a | b);
        f[IDX_XNOR] = ~(a ^ b);
    end

endmodule

// File: rtl/gate_vector_checker.sv
// Sweeps {vec_a,vec_b} through 00..11 for NUM_PASSES passes and counts mismatching vectors.
// Define GATE_CHECK_LOG_EN to add the first-failure log outputs.
module gate_vector_checker
    import gate_check_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int NUM_PASSES    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             vec_a,
    output logic             vec_b,
    input  logic [RES_W-1:0] dut_f,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [3:0]       err_count
`ifdef GATE_CHECK_LOG_EN
    ,
    output logic             fail_valid,
    output logic [VEC_W-1:0] first_fail_vec,
    output logic [RES_W-1:0] first_fail_mask
`endif
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_PASS   = CNT_W'(NUM_PASSES - 1);

    state_t           state;
    logic [CNT_W-1:0] settle_cnt;
    logic [CNT_W-1:0] pass_cnt;
    logic [RES_W-1:0] golden;
    logic [RES_W-1:0] fail_mask;
    logic             mismatch;
    logic [3:0]       err_next;

    gate_golden u_golden (
        .a (vec_a),
        .b (vec_b),
        .f (golden)
    );

    // Any number of differing bits counts as a single failing vector.
    assign fail_mask = dut_f ^ golden;
    assign mismatch  = |fail_mask;
    assign err_next  = (mismatch && err_count != 4'hF) ? err_count + 4'd1 : err_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            pass_cnt   <= '0;
            vec_a      <= 1'b0;
            vec_b      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        {vec_a, vec_b} <= 2'b00;
                        settle_cnt     <= SETTLE_LOAD;
                        pass_cnt       <= '0;
                        err_count      <= '0;
                        pass           <= 1'b0;
                        busy           <= 1'b1;
                        state          <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == '0) state <= CHECK;
                    else                  settle_cnt <= settle_cnt - 1'b1;
                end
                CHECK: begin
                    err_count <= err_next;
                    // The final vector of the final pass leaves the stimulus at 11.
                    if ({vec_a, vec_b} == 2'b11 && pass_cnt == LAST_PASS) begin
                        done  <= 1'b1;
                        pass  <= (err_next == 4'd0);
                        state <= DONE;
                    end else begin
                        if ({vec_a, vec_b} == 2'b11) pass_cnt <= pass_cnt + 1'b1;
                        {vec_a, vec_b} <= {vec_a, vec_b} + 2'd1;
                        settle_cnt     <= SETTLE_LOAD;
                        state          <= SETTLE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GATE_CHECK_LOG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_valid      <= 1'b0;
            first_fail_vec  <= '0;
            first_fail_mask <= '0;
        end else if (state == IDLE && start) begin
            fail_valid      <= 1'b0;
            first_fail_vec  <= '0;
            first_fail_mask <= '0;
        end else if (state == CHECK && mismatch && !fail_valid) begin
            fail_valid      <= 1'b1;
            first_fail_vec  <= {vec_a, vec_b};
            first_fail_mask <= fail_mask;
        end
    end
`endif

endmodule
